// File: rtl/div_pkg.sv
// Shared types for the sequential signed divider.
// Holds the controller state encoding and default widths.
package div_pkg;

  localparam int DIV_WIDTH = 6;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One non-restoring division step (combinational).
// Ports: p/ay/q_msb in; p_next and quotient bit q_bit out.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH+1:0] p,
  input  logic [WIDTH:0]   ay,
  input  logic             q_msb,
  output logic [WIDTH+1:0] p_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] p_sh;
  logic [WIDTH+1:0] d;

  always_comb begin
    p_sh   = {p[WIDTH:0], q_msb};
    d      = {1'b0, ay};
    // sign of P decides subtract or add back
    p_next = p[WIDTH+1] ? p_sh + d : p_sh - d;
    q_bit  = ~p_next[WIDTH+1];
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider, one non-restoring step per cycle.
// Ports: clk, rst_n, start, X, Y in; busy, done, w={q,r}, dbz, ovf out.
module booth_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] w,
  output logic               dbz,
  output logic               ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state;

  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [WIDTH-1:0] qr;
  logic [WIDTH:0]   ay;
  logic [WIDTH+1:0] p;
  logic [WIDTH+1:0] p_nx;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic             q_bit;

  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH+1:0] r_mag;
  logic [WIDTH+1:0] r_neg;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             dbz_c;
  logic             ovf_c;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p     (p),
    .ay    (ay),
    .q_msb (qr[WIDTH-1]),
    .p_next(p_nx),
    .q_bit (q_bit)
  );

  // |most negative| still fits as an unsigned WIDTH-bit value
  always_comb begin
    x_mag = xr[WIDTH-1] ? -xr : xr;
    y_mag = yr[WIDTH-1] ? -yr : yr;
    r_mag = p[WIDTH+1] ? p + {1'b0, ay} : p;
    r_neg = -r_mag;
    q_fix = sign_q ? -qr : qr;
    r_fix = sign_r ? r_neg[WIDTH-1:0]
                   : r_mag[WIDTH-1:0];
    dbz_c = (yr == '0);
    ovf_c = (xr == MINV) && (&yr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      w      <= '0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      qr     <= '0;
      ay     <= '0;
      p      <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            xr    <= X;
            yr    <= Y;
            busy  <= 1'b1;
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          ay     <= {1'b0, y_mag};
          qr     <= x_mag;
          sign_q <= xr[WIDTH-1] ^ yr[WIDTH-1];
          sign_r <= xr[WIDTH-1];
          p      <= '0;
          cnt    <= '0;
          state  <= ITER;
        end
        ITER: begin
          p   <= p_nx;
          qr  <= {qr[WIDTH-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (dbz_c) begin
            w   <= {{WIDTH{1'b1}}, xr};
            dbz <= 1'b1;
            ovf <= 1'b0;
          end else if (ovf_c) begin
            w   <= {MINV, {WIDTH{1'b0}}};
            dbz <= 1'b0;
            ovf <= 1'b1;
          end else begin
            w   <= {q_fix, r_fix};
            dbz <= 1'b0;
            ovf <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider against an integer model.
// Driver pushes expectations; monitor pops on each done pulse.
module tb_booth_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  X;
  logic [5:0]  Y;
  logic        busy;
  logic        done;
  logic [11:0] w;
  logic        dbz;
  logic        ovf;

  typedef struct {
    logic [11:0] w;
    logic        dbz;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  booth_divider #(.WIDTH(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .X    (X),
    .Y    (Y),
    .busy (busy),
    .done (done),
    .w    (w),
    .dbz  (dbz),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int x, input int y,
                                 input int due);
    exp_t e;
    int q;
    int r;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (y == 0) begin
      q = -1;
      r = x;
      e.dbz = 1'b1;
    end else if (x == -32 && y == -1) begin
      q = -32;
      r = 0;
      e.ovf = 1'b1;
    end else begin
      q = x / y;
      r = x % y;
    end
    e.w = {q[5:0], r[5:0]};
    e.due = due;
    return e;
  endfunction

  task automatic chk(input string name, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called right after a falling edge; start is sampled next edge.
  task automatic issue(input logic signed [5:0] x,
                       input logic signed [5:0] y);
    X = x;
    Y = y;
    start = 1'b1;
    sb.push_back(model(int'(x), int'(y), cyc + 9));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: w=%h at cycle %0d", w, cyc);
      end else begin
        e = sb.pop_front();
        chk("w", int'(w), int'(e.w));
        chk("dbz", int'(dbz), int'(e.dbz));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("latency", cyc, e.due);
      end
    end
  end

  initial begin
    logic signed [5:0] xa;
    logic signed [5:0] ya;
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    X = '0;
    Y = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_w", int'(w), 0);
    chk("rst_dbz", int'(dbz), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(6'sd27, 6'sd5);     wait_done(); @(negedge clk);
    issue(-6'sd27, 6'sd5);    wait_done(); @(negedge clk);
    issue(6'sd27, -6'sd5);    wait_done(); @(negedge clk);
    issue(6'sd13, 6'sd0);     wait_done(); @(negedge clk);
    issue(-6'sd32, -6'sd1);   wait_done(); @(negedge clk);
    issue(-6'sd32, 6'sd1);    wait_done(); @(negedge clk);
    issue(-6'sd32, 6'sd0);    wait_done(); @(negedge clk);
    issue(6'sd31, -6'sd32);   wait_done(); @(negedge clk);

    // start while busy must not disturb the running division
    issue(6'sd27, 6'sd5);
    @(negedge clk);
    X = 6'd7;
    Y = 6'd3;
    start = 1'b1;
    chk("busy_mid", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // back-to-back: each start lands in the DONE cycle
    for (int i = 0; i < 40; i++) begin
      xa = 6'($urandom);
      ya = 6'($urandom);
      if (i % 9 == 0) ya = '0;
      issue(xa, ya);
      wait_done();
    end
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      xa = 6'($urandom);
      ya = 6'($urandom);
      if (i % 11 == 0) begin
        xa = -6'sd32;
        ya = -6'sd1;
      end
      issue(xa, ya);
      wait_done();
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    // reset in the middle of a computation
    @(negedge clk);
    issue(6'sd20, 6'sd3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_w", int'(w), 0);
    sb.delete();
    dc = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", done_cnt, dc);

    issue(-6'sd17, 6'sd4);
    wait_done();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
